mips_run_ctrl: RTL and testbench

Front-panel run/step controller sitting directly upstream of the `mips` core. It conditions the raw board slide switch and push-button and drives the core's `switch` input (core executes while `switch`=1). It supports free-run and single-cycle step modes, a post-reset hold window, and an executed-cycle counter for the LED/debug path.

---
 rtl/mips_ctrl_pkg.sv | 16 +
 rtl/sync_debounce.sv | 45 ++++
 rtl/mips_run_ctrl.sv | 116 +++++++++++
 tb/tb_mips_run_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and default parameters for the front-panel run/step controller.
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      HOLD     = 3'd0,
      IDLE     = 3'd1,
      RUN      = 3'd2,
      STEP     = 3'd3,
      WAIT_REL = 3'd4
   } run_state_t;

   localparam int DEF_DEB_CYCLES  = 16;
   localparam int DEF_HOLD_CYCLES = 5;
   localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer for one board input.
// The debounced level follows only after DEB_CYCLES consecutive differing samples.
module sync_debounce
   import mips_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   output logic o_db
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_db;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_db  <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= i_raw;
         r_s2 <= r_s1;
         // Any sample agreeing with the current level restarts the stability count.
         if (r_s2 == r_db) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_db  <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_db = r_db;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/step controller driving the mips core's switch input from the board switch and button.
// Post-reset hold window, free-run and single-cycle step modes, executed-cycle counter.
module mips_run_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
   parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sw_raw,
   input  logic             btn_raw,
   output logic             cpu_switch,
   output logic             mode_run,
   output logic [CNT_W-1:0] en_count
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

   logic             w_sw_db;
   logic             w_btn_db;
   logic             w_btn_rise;
   logic             r_btn_d;
   run_state_t       r_state;
   logic [HW-1:0]    r_hold_cnt;
   logic             r_cpu_switch;
   logic             r_mode_run;
   logic [CNT_W-1:0] r_en_count;

   sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw_deb (
      .clk   (clk),
      .rst   (rst),
      .i_raw (sw_raw),
      .o_db  (w_sw_db)
   );

   sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
      .clk   (clk),
      .rst   (rst),
      .i_raw (btn_raw),
      .o_db  (w_btn_db)
   );

   assign w_btn_rise = w_btn_db & ~r_btn_d;

   // Outputs are registered alongside the state so they always match the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= HOLD;
         r_hold_cnt   <= '0;
         r_btn_d      <= 1'b0;
         r_cpu_switch <= 1'b0;
         r_mode_run   <= 1'b0;
         r_en_count   <= '0;
      end else begin
         r_btn_d <= w_btn_db;
         if (r_cpu_switch) begin
            r_en_count <= r_en_count + CNT_W'(1);
         end
         case (r_state)
            HOLD: begin
               if (r_hold_cnt == HOLD_MAX) begin
                  r_state    <= IDLE;
                  r_hold_cnt <= '0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + HW'(1);
               end
            end
            IDLE: begin
               // A switch-on arriving with a press wins; the press is dropped.
               if (w_sw_db) begin
                  r_state      <= RUN;
                  r_cpu_switch <= 1'b1;
                  r_mode_run   <= 1'b1;
               end else if (w_btn_rise) begin
                  r_state      <= STEP;
                  r_cpu_switch <= 1'b1;
               end
            end
            RUN: begin
               if (!w_sw_db) begin
                  r_state      <= IDLE;
                  r_cpu_switch <= 1'b0;
                  r_mode_run   <= 1'b0;
               end
            end
            STEP: begin
               r_state      <= WAIT_REL;
               r_cpu_switch <= 1'b0;
            end
            WAIT_REL: begin
               if (w_sw_db) begin
                  r_state      <= RUN;
                  r_cpu_switch <= 1'b1;
                  r_mode_run   <= 1'b1;
               end else if (!w_btn_db) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state      <= HOLD;
               r_hold_cnt   <= '0;
               r_cpu_switch <= 1'b0;
               r_mode_run   <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_switch = r_cpu_switch;
   assign mode_run   = r_mode_run;
   assign en_count   = r_en_count;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed scenarios plus random switch/button traffic
// against a behavioural model; a 4-bit-counter instance shares the inputs for wrap checks.
module tb_mips_run_ctrl;

   localparam int DEB  = 4;
   localparam int HOLD = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        sw_raw;
   logic        btn_raw;
   logic        cpu_a, run_a, cpu_b, run_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   mips_run_ctrl #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CNT_W(16)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .sw_raw     (sw_raw),
      .btn_raw    (btn_raw),
      .cpu_switch (cpu_a),
      .mode_run   (run_a),
      .en_count   (cnt_a)
   );

   mips_run_ctrl #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CNT_W(4)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .sw_raw     (sw_raw),
      .btn_raw    (btn_raw),
      .cpu_switch (cpu_b),
      .mode_run   (run_b),
      .en_count   (cnt_b)
   );

   // Behavioural model: raw inputs reach the debouncer two edges late; a level is
   // accepted once the last DEB samples all disagree with the current level.
   bit sw_pipe[$];
   bit btn_pipe[$];
   bit sw_win[$];
   bit btn_win[$];
   bit m_sw_db, m_btn_db, m_btn_prev;
   int m_hold_left;
   bit m_run, m_pulse, m_waiting;
   bit m_cpu;
   int m_en;

   function automatic bit all_differ(bit win[$], bit lvl);
      if (win.size() < DEB) return 1'b0;
      foreach (win[i]) if (win[i] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      sw_pipe = '{1'b0, 1'b0};
      btn_pipe = '{1'b0, 1'b0};
      sw_win.delete();
      btn_win.delete();
      m_sw_db = 0; m_btn_db = 0; m_btn_prev = 0;
      m_hold_left = HOLD;
      m_run = 0; m_pulse = 0; m_waiting = 0;
      m_cpu = 0;
      m_en = 0;
   endtask

   task automatic model_step();
      bit smp, rise;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_cpu) m_en = m_en + 1;
      rise = m_btn_db && !m_btn_prev;
      if (m_hold_left > 0) begin
         m_hold_left = m_hold_left - 1;
      end else if (m_pulse) begin
         m_pulse = 0;
         m_waiting = 1;
      end else if (m_run) begin
         if (!m_sw_db) m_run = 0;
      end else if (m_waiting) begin
         if (m_sw_db) begin
            m_run = 1;
            m_waiting = 0;
         end else if (!m_btn_db) begin
            m_waiting = 0;
         end
      end else begin
         if (m_sw_db) m_run = 1;
         else if (rise) m_pulse = 1;
      end
      m_btn_prev = m_btn_db;

      smp = sw_pipe.pop_front();
      sw_pipe.push_back(sw_raw);
      sw_win.push_back(smp);
      if (sw_win.size() > DEB) void'(sw_win.pop_front());
      if (all_differ(sw_win, m_sw_db)) begin
         m_sw_db = !m_sw_db;
         sw_win.delete();
      end

      smp = btn_pipe.pop_front();
      btn_pipe.push_back(btn_raw);
      btn_win.push_back(smp);
      if (btn_win.size() > DEB) void'(btn_win.pop_front());
      if (all_differ(btn_win, m_btn_db)) begin
         m_btn_db = !m_btn_db;
         btn_win.delete();
      end

      m_cpu = m_run || m_pulse;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_model();
      check("cpu_switch", {31'd0, cpu_a}, {31'd0, m_cpu});
      check("mode_run", {31'd0, run_a}, {31'd0, m_run});
      check("en_count16", {16'd0, cnt_a}, m_en & 32'hFFFF);
      check("cpu_switch4", {31'd0, cpu_b}, {31'd0, m_cpu});
      check("en_count4", {28'd0, cnt_b}, m_en & 32'hF);
   endtask

   // One clock: model follows the edge, outputs are checked on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      ticks(n);
      rst = 1'b0;
   endtask

   task automatic wait_cpu(input string tag, input int budget);
      int k;
      k = 0;
      while (cpu_a !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      if (cpu_a !== 1'b1) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int pulses, hi_cycles, saved_en, seen, step_seen;
      bit prev_cpu;
      model_reset();
      rst = 1'b1;
      sw_raw = 1'b1;
      btn_raw = 1'b0;

      // Reset start with the switch already on.
      ticks(2);
      check("reset_cpu", {31'd0, cpu_a}, 32'd0);
      check("reset_cnt", {16'd0, cnt_a}, 32'd0);
      rst = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         check("rs_cpu_edge", {31'd0, cpu_a}, (e >= 7) ? 32'd1 : 32'd0);
         check("rs_run_edge", {31'd0, run_a}, (e >= 7) ? 32'd1 : 32'd0);
      end
      check("rs_cnt", {16'd0, cnt_a}, 32'd5);

      // Glitch rejection from IDLE.
      sw_raw = 1'b0;
      ticks(12);
      saved_en = m_en;
      seen = 0;
      sw_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (cpu_a === 1'b1) seen++;
      end
      sw_raw = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (cpu_a === 1'b1) seen++;
      end
      check("glitch_cpu", seen, 32'd0);
      check("glitch_cnt", {16'd0, cnt_a}, saved_en);

      // Single step: two presses give two one-cycle pulses.
      pulses = 0;
      hi_cycles = 0;
      prev_cpu = 1'b0;
      saved_en = m_en;
      for (int r = 0; r < 2; r++) begin
         for (int ph = 0; ph < 2; ph++) begin
            btn_raw = (ph == 0);
            for (int i = 0; i < 20; i++) begin
               tick();
               if (cpu_a === 1'b1) hi_cycles++;
               if (cpu_a === 1'b1 && !prev_cpu) pulses++;
               prev_cpu = (cpu_a === 1'b1);
            end
         end
      end
      check("step_pulses", pulses, 32'd2);
      check("step_width", hi_cycles, 32'd2);
      check("step_cnt", {16'd0, cnt_a}, saved_en + 2);

      // Priority: switch and button together go straight to RUN.
      step_seen = 0;
      sw_raw = 1'b1;
      btn_raw = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_a === 1'b1 && run_a !== 1'b1) step_seen++;
      end
      check("prio_run", {31'd0, run_a}, 32'd1);
      // Switch off with the button still held: no step.
      sw_raw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_a === 1'b1 && run_a !== 1'b1) step_seen++;
      end
      check("prio_nostep", step_seen, 32'd0);
      check("held_idle_cpu", {31'd0, cpu_a}, 32'd0);
      btn_raw = 1'b0;
      ticks(10);

      // Wrap of the 4-bit counter after 17 run cycles.
      do_reset(1);
      sw_raw = 1'b1;
      wait_cpu("wrap", 40);
      ticks(17);
      check("wrap4", {28'd0, cnt_b}, 32'd1);
      check("wrap16", {16'd0, cnt_a}, 32'd17);

      // Reset mid-run with en_count at 9.
      do_reset(1);
      wait_cpu("midrst", 40);
      ticks(9);
      check("midrst_pre", {16'd0, cnt_a}, 32'd9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_cpu", {31'd0, cpu_a}, 32'd0);
      check("midrst_run", {31'd0, run_a}, 32'd0);
      check("midrst_cnt", {16'd0, cnt_a}, 32'd0);
      ticks(HOLD);
      check("midrst_hold", {31'd0, cpu_a}, 32'd0);

      // Random traffic with occasional resets.
      for (int seg = 0; seg < 400; seg++) begin
         sw_raw = ($urandom_range(0, 2) == 0);
         btn_raw = $urandom_range(0, 1);
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         ticks($urandom_range(1, 14));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
